// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch / lap timer block.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE    = 2'd0,
    SW_RUNNING = 2'd1,
    SW_PAUSED  = 2'd2
  } sw_state_t;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stopwatch_lap_timer_if.sv
// Lap stream from the stopwatch to its consumer: head data, valid/ready, level, overflow.
interface stopwatch_lap_timer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LVL_W      = 3
);
  logic [DATA_WIDTH-1:0] lap_data;
  logic                  lap_valid;
  logic                  lap_ready;
  logic [LVL_W-1:0]      lap_level;
  logic                  lap_overflow;

  modport master (
    output lap_data, lap_valid, lap_level, lap_overflow,
    input  lap_ready
  );

  modport slave (
    input  lap_data, lap_valid, lap_level, lap_overflow,
    output lap_ready
  );
endinterface

// File: rtl/lap_fifo.sv
// Synchronous lap-capture FIFO with async reset, sync clear and sticky overflow.
module lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned LvlW = level_width(DEPTH),
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [LvlW-1:0]  level_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             full, do_pop, do_push;

  assign full    = (level_q == LvlW'(DEPTH));
  assign empty_o = (level_q == '0);
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);

  // Next-state for pointers, level, storage and the sticky overflow flag.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_i && full && !do_pop) ovf_d = 1'b1;
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  assign head_o     = mem_q[rd_ptr_q];
  assign level_o    = level_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/stopwatch_lap_timer.sv
// Stopwatch with prescaler, wrap at MAX, sync clear and a lap-capture FIFO.
// Optional build macro STOPWATCH_SATURATE_EN: a tick at MAX holds the count at MAX,
// forces PAUSED and pulses wrap as an expiry flag instead of wrapping to 0.
module stopwatch_lap_timer
  import stopwatch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX        = 99,
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned LAP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  running,
  output logic                  wrap,
  stopwatch_lap_timer_if.master lap_if
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  sw_state_t             state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic                  start_z_q, stop_z_q, lap_z_q;
  logic                  start_edge, stop_edge, lap_edge, tick;

  assign start_edge = start & ~start_z_q;
  assign stop_edge  = stop & ~stop_z_q;
  assign lap_edge   = lap & ~lap_z_q;

  // Control FSM, prescaler and counter next-state; clear beats stop beats start.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    tick    = 1'b0;
    if (clear) begin
      state_d = SW_IDLE;
      presc_d = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        SW_IDLE: begin
          if (start_edge && !stop_edge) begin
            state_d = SW_RUNNING;
            presc_d = '0;
          end
        end
        SW_RUNNING: begin
          if (stop_edge) begin
            state_d = SW_PAUSED;
          end else if (presc_q == PW'(TICK_DIV - 1)) begin
            presc_d = '0;
            tick    = 1'b1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        SW_PAUSED: begin
          if (start_edge && !stop_edge) state_d = SW_RUNNING;
        end
        default: state_d = SW_IDLE;
      endcase
      if (tick) begin
        if (count_q == DATA_WIDTH'(MAX)) begin
          wrap_d = 1'b1;
`ifdef STOPWATCH_SATURATE_EN
          state_d = SW_PAUSED;
`else
          count_d = '0;
`endif
        end else begin
          count_d = count_q + DATA_WIDTH'(1);
        end
      end
    end
  end

  // State, counter and edge-detect registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SW_IDLE;
      presc_q   <= '0;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      start_z_q <= 1'b0;
      stop_z_q  <= 1'b0;
      lap_z_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      start_z_q <= start;
      stop_z_q  <= stop;
      lap_z_q   <= lap;
    end
  end

  logic fifo_empty;

  // Laps capture the pre-increment count; a same-cycle clear discards them.
  lap_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (clear),
    .push_i      (lap_edge & ~clear & (state_q != SW_IDLE)),
    .push_data_i (count_q),
    .pop_i       (lap_if.lap_ready),
    .head_o      (lap_if.lap_data),
    .empty_o     (fifo_empty),
    .level_o     (lap_if.lap_level),
    .overflow_o  (lap_if.lap_overflow)
  );

  assign lap_if.lap_valid = ~fifo_empty;
  assign count            = count_q;
  assign running          = (state_q == SW_RUNNING);
  assign wrap             = wrap_q;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Bench: two stopwatch instances (MAX=9/DIV=1 and MAX=99/DIV=4) driven in lockstep,
// checked every cycle against an elapsed-time reference model plus directed expectations.
module tb_stopwatch_lap_timer;

  logic clk = 1'b0;
  logic reset, start, stop, clear, lap, rdy;
  always #5 clk = ~clk;

  logic [7:0]  cnt_a;
  logic [15:0] cnt_b;
  logic        run_a, run_b, wrap_a, wrap_b;

  stopwatch_lap_timer_if #(.DATA_WIDTH(8),  .LVL_W(3)) if_a ();
  stopwatch_lap_timer_if #(.DATA_WIDTH(16), .LVL_W(3)) if_b ();
  assign if_a.lap_ready = rdy;
  assign if_b.lap_ready = rdy;

  stopwatch_lap_timer #(.DATA_WIDTH(8), .MAX(9), .TICK_DIV(1), .LAP_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .count(cnt_a), .running(run_a), .wrap(wrap_a), .lap_if(if_a)
  );
  stopwatch_lap_timer #(.DATA_WIDTH(16), .MAX(99), .TICK_DIV(4), .LAP_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .count(cnt_b), .running(run_b), .wrap(wrap_b), .lap_if(if_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: st 0=idle 1=running 2=paused; act = cycles spent advancing.
  int m_st[2], m_act[2], m_wrap[2], m_ovf[2];
  int q0[$], q1[$];
  logic sz, pz, lz;

  function automatic int m_max(input int k); return (k == 0) ? 9 : 99; endfunction
  function automatic int m_div(input int k); return (k == 0) ? 1 : 4; endfunction
  function automatic int m_count(input int k);
    return (m_act[k] / m_div(k)) % (m_max(k) + 1);
  endfunction
  function automatic int qsize(input int k); return (k == 0) ? q0.size() : q1.size(); endfunction
  function automatic int qhead(input int k); return (k == 0) ? q0[0] : q1[0]; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_act[k] = 0; m_wrap[k] = 0; m_ovf[k] = 0;
    end
    q0.delete(); q1.delete();
    sz = 1'b0; pz = 1'b0; lz = 1'b0;
  endtask

  task automatic model_k(input int k);
    bit se, pe, le, pop, push;
    int cur;
    se = start && !sz; pe = stop && !pz; le = lap && !lz;
    if (clear) begin
      m_st[k] = 0; m_act[k] = 0; m_wrap[k] = 0; m_ovf[k] = 0;
      if (k == 0) q0.delete(); else q1.delete();
    end else begin
      cur = m_count(k);
      m_wrap[k] = 0;
      pop  = (qsize(k) > 0) && rdy;
      push = le && (m_st[k] != 0);
      if (push && qsize(k) == 4 && !pop) begin
        m_ovf[k] = 1;
      end else begin
        if (pop)  begin if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front()); end
        if (push) begin if (k == 0) q0.push_back(cur); else q1.push_back(cur); end
      end
      if (m_st[k] == 1 && !pe) begin
        m_act[k]++;
        if (m_act[k] % m_div(k) == 0 && m_count(k) == 0) m_wrap[k] = 1;
      end
      if (m_st[k] == 1 && pe) m_st[k] = 2;
      else if (m_st[k] != 1 && se && !pe) m_st[k] = 1;
    end
  endtask

  task automatic check_all(input int k);
    string p;
    p = (k == 0) ? "a" : "b";
    chk({p, "_count"}, (k == 0) ? 32'(cnt_a) : 32'(cnt_b), m_count(k));
    chk({p, "_running"}, (k == 0) ? 32'(run_a) : 32'(run_b), m_st[k] == 1);
    chk({p, "_wrap"}, (k == 0) ? 32'(wrap_a) : 32'(wrap_b), m_wrap[k]);
    chk({p, "_valid"}, (k == 0) ? 32'(if_a.lap_valid) : 32'(if_b.lap_valid), qsize(k) > 0);
    chk({p, "_level"}, (k == 0) ? 32'(if_a.lap_level) : 32'(if_b.lap_level), qsize(k));
    chk({p, "_ovf"}, (k == 0) ? 32'(if_a.lap_overflow) : 32'(if_b.lap_overflow), m_ovf[k]);
    if (qsize(k) > 0)
      chk({p, "_data"}, (k == 0) ? 32'(if_a.lap_data) : 32'(if_b.lap_data), qhead(k));
  endtask

  // One clock: advance model from the inputs present at the edge, then compare.
  task automatic step();
    model_k(0);
    model_k(1);
    sz = start; pz = stop; lz = lap;
    @(posedge clk);
    #1;
    check_all(0);
    check_all(1);
  endtask

  initial begin
    int lap_tgt[5];
    int n;
    lap_tgt = '{3, 5, 7, 9, 11};
    reset = 1'b1; start = 0; stop = 0; clear = 0; lap = 0; rdy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all(0);
    check_all(1);
    reset = 1'b0;

    // Count sequence with wrap on A.
    start = 1; step(); start = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("a_seq_count", 32'(cnt_a), i % 10);
      chk("a_seq_wrap", 32'(wrap_a), (i == 10) ? 1 : 0);
    end

    // Prescaler hold across pause on B.
    clear = 1; step(); clear = 0;
    start = 1; step(); start = 0;
    repeat (10) step();
    stop = 1; step(); stop = 0;
    chk("b_count_at_stop", 32'(cnt_b), 2);
    repeat (8) step();
    chk("b_count_paused", 32'(cnt_b), 2);
    start = 1; step(); start = 0;
    repeat (6) step();
    chk("b_count_resumed", 32'(cnt_b), 4);
    chk("b_running_resumed", 32'(run_b), 1);

    // Simultaneous start/stop: from RUNNING pauses, from IDLE stays idle.
    start = 1; stop = 1; step(); start = 0; stop = 0;
    chk("b_same_cycle_run", 32'(run_b), 0);
    repeat (3) step();
    chk("b_same_cycle_frozen", 32'(cnt_b), 4);
    clear = 1; step(); clear = 0;
    start = 1; stop = 1; step(); start = 0; stop = 0;
    chk("b_idle_both_run", 32'(run_b), 0);
    chk("b_idle_both_count", 32'(cnt_b), 0);

    // Lap overflow and drain on B.
    rdy = 0;
    clear = 1; step(); clear = 0;
    start = 1; step(); start = 0;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (m_count(1) != lap_tgt[i] && n < 200) begin step(); n++; end
      chk("b_lap_reach", 32'(cnt_b), lap_tgt[i]);
      lap = 1; step(); lap = 0;
    end
    chk("b_lap_level_full", 32'(if_b.lap_level), 4);
    chk("b_lap_overflow", 32'(if_b.lap_overflow), 1);
    rdy = 1;
    for (int i = 0; i < 4; i++) begin
      chk("b_drain_valid", 32'(if_b.lap_valid), 1);
      chk("b_drain_data", 32'(if_b.lap_data), lap_tgt[i]);
      step();
    end
    chk("b_drain_empty", 32'(if_b.lap_valid), 0);

    // Randomized control traffic.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 9) == 0);
      lap   = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 60) == 0);
      rdy   = ($urandom_range(0, 2) == 0);
      step();
    end
    start = 0; stop = 0; lap = 0; clear = 0; rdy = 0;

    // Asynchronous reset mid-run, start held through release.
    clear = 1; step(); clear = 0;
    start = 1; step(); start = 0;
    n = 0;
    while (m_count(1) != 37 && n < 400) begin step(); n++; end
    chk("b_pre_reset_count", 32'(cnt_b), 37);
    #2 reset = 1;
    #1;
    chk("rst_a_count", 32'(cnt_a), 0);
    chk("rst_b_count", 32'(cnt_b), 0);
    chk("rst_b_running", 32'(run_b), 0);
    chk("rst_b_valid", 32'(if_b.lap_valid), 0);
    chk("rst_b_level", 32'(if_b.lap_level), 0);
    chk("rst_b_data", 32'(if_b.lap_data), 0);
    model_reset();
    start = 1;
    #3 reset = 0;
    step();
    chk("b_start_held_run", 32'(run_b), 1);
    chk("a_start_held_run", 32'(run_a), 1);
    start = 0;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stopwatch_lap_timer.md
Name: stopwatch_lap_timer

Overview:
Parametrised successor to the single-counter stopwatch. Adds a clock prescaler, wrap at a programmable MAX, a synchronous clear, and a lap-capture FIFO drained through a valid/ready handshake. It sits beside the free-running system clock and feeds lap times to a host or display block. Control inputs are edge-triggered.

Parameters:
DATA_WIDTH, 16, width of count and lap data; MAX < 2**DATA_WIDTH
MAX, 99, terminal count; must be >= 1
TICK_DIV, 1, clk cycles per count increment; must be >= 1
LAP_DEPTH, 4, lap FIFO entries; power of 2, >= 2

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  rising edge starts or resumes
stop  in  1  rising edge pauses
clear  in  1  synchronous level clear (count, prescaler, FIFO, overflow, state)
lap  in  1  rising edge captures the current count into the FIFO
count  out  DATA_WIDTH  current elapsed count
running  out  1  high in the RUNNING state
wrap  out  1  one-cycle pulse on a MAX->0 transition
lap_data  out  DATA_WIDTH  FIFO head
lap_valid  out  1  FIFO not empty
lap_ready  in  1  consumer accepts lap_data when lap_valid & lap_ready
lap_level  out  $clog2(LAP_DEPTH+1)  FIFO occupancy
lap_overflow  out  1  sticky; set when a lap is dropped because the FIFO is full

Behaviour:
- Reset (async, active-high):
  - all outputs = 0; state = IDLE.
  - Edge-detect registers (start_z, stop_z, lap_z) = 0, so an input held high across reset release is seen as an edge on the first clock.
- Edge detection: x_edge = x & ~x_z; x_z registers x every cycle.
- States are IDLE, RUNNING and PAUSED. Priority per cycle: clear > stop_edge > start_edge.
  - clear: state = IDLE, count = 0, prescaler = 0, FIFO flushed, lap_overflow = 0, wrap = 0. Any lap edge in the same cycle is discarded.
  - IDLE: start_edge -> RUNNING with prescaler = 0. stop_edge is ignored.
  - RUNNING: stop_edge -> PAUSED; the prescaler and count hold their values.
  - PAUSED: start_edge -> RUNNING; the prescaler resumes from its held value.
  - start_edge and stop_edge in the same cycle: stop wins (RUNNING -> PAUSED; IDLE stays IDLE).
- Prescaler: advances only in RUNNING. tick = (presc == TICK_DIV-1); on tick, presc = 0.
  - First increment is TICK_DIV cycles after the start edge is sampled. With TICK_DIV=1, count = 1 one cycle after running rises.
  - The transition cycle out of RUNNING (stop_edge) produces no tick.
- Count on tick: count == MAX -> count = 0 and wrap = 1 for that cycle; otherwise count + 1. Arithmetic is unsigned DATA_WIDTH.
- Lap capture: a lap_edge in RUNNING or PAUSED pushes the registered count (the value before any same-cycle increment). lap_edge in IDLE is ignored.
- FIFO:
  - lap_data is the registered head; pop on lap_valid & lap_ready.
  - Push while full and no pop: data dropped, lap_overflow = 1.
  - Push and pop in the same cycle while full: both occur, level unchanged, no overflow.
  - Push into empty: lap_valid rises the next cycle.
  - Pop while empty: no effect.

Optional Feature:
STOPWATCH_SATURATE_EN:
- Defined: a tick at count == MAX holds count at MAX, forces state to PAUSED, and pulses wrap once as an expiry indication. A subsequent start_edge resumes, but count stays at MAX until clear.
- Undefined: wrap-around behaviour as above.

Decomposition:
- Package stopwatch_pkg: typedef enum logic [1:0] {SW_IDLE, SW_RUNNING, SW_PAUSED} sw_state_t; function clog2-based level-width helper.
- Sub-module lap_fifo #(WIDTH, DEPTH): synchronous FIFO with async reset, push/pop/full/empty/level/overflow. The top module keeps the FSM, prescaler and counter.

Test Plan:
- TICK_DIV=1, MAX=9: reset, start pulse, run 12 cycles -> count sequence 1..9,0,1,2; wrap high only on the 9->0 cycle.
- TICK_DIV=4: start, 10 cycles, stop, 8 idle cycles, start, 6 cycles -> count = 2 at stop, held through pause, then 4 (prescaler resumed at 2/4).
- start and stop rising in the same cycle from RUNNING -> PAUSED, count frozen; from IDLE -> stays IDLE, count 0.
- LAP_DEPTH=4, lap_ready=0: 5 lap pulses at counts 3,5,7,9,11 -> lap_level=4, lap_overflow=1. Drain with lap_ready=1 -> lap_data 3,5,7,9, then lap_valid=0.
- Assert reset mid-run (count=37) asynchronously between clock edges -> all outputs 0 immediately. Hold start high through reset release -> RUNNING on the first clk.
- STOPWATCH_SATURATE_EN, MAX=5: run -> count stops at 5, running=0, single wrap pulse. clear -> count 0, IDLE.
